// File: rtl/jtag_shift_master.sv
// jtag_shift_master: word-level JTAG initiator.
// Turns IR-scan, DR-scan and TAP-reset commands into exact TMS/TDI bit
// sequences, samples TDO back into a response word and always parks the
// TAP in Run-Test/Idle between commands.
//
// Handshake: a command transfers on a rising edge where cmd_valid_i and
// cmd_ready_o are both high; cmd_ready_o is high only while the master sits
// in IDLE (RTI), and cmd_valid_i seen while busy is dropped, not queued.
// rsp_valid_o is a single-cycle pulse with no back-pressure; rsp_data_o and
// rsp_oe_err_o hold their value until the next completion (the OE error
// flag additionally clears when the next command is accepted).
module jtag_shift_master #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               tck_pad_i,
  input  logic               trst_pad_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [LEN_W-1:0]   cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               tms_pad_o,
  output logic               tdi_pad_o,
  input  logic               tdo_pad_i,
  input  logic               tdo_padoe_i,
  output logic               rsp_valid_o,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               rsp_oe_err_o,
  output logic [2:0]         dbg_state_o
);

  localparam int IDX_W = $clog2(MAX_LEN);

  // INIT and TAP-reset both drive TMS high for this many cycles, then one
  // TMS-low cycle (Test-Logic-Reset -> Run-Test/Idle).
  localparam logic [LEN_W-1:0] RST_HI_LAST = LEN_W'(4);
  localparam logic [LEN_W-1:0] RST_LO_CYC  = LEN_W'(5);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,  // power-on / trst sequence, no response
    S_IDLE  = 3'd1,  // parked in RTI, accepting commands
    S_PRE   = 3'd2,  // walk from RTI to Shift-DR / Shift-IR
    S_SHIFT = 3'd3,  // N shift cycles, last one exits to Exit1
    S_POST  = 3'd4,  // Exit1 -> Update -> RTI
    S_TRST  = 3'd5   // TAP-reset command, responds on completion
  } state_t;

  state_t               state_q;
  logic [LEN_W-1:0]     cnt_q;
  logic [LEN_W-1:0]     len_q;
  logic                 ir_q;
  logic [MAX_LEN-1:0]   data_q;
  logic [MAX_LEN-1:0]   cap_q;
  logic                 err_q;
  logic                 tms_q;
  logic                 tdi_q;
  logic                 rsp_valid_q;
  logic [MAX_LEN-1:0]   rsp_data_q;
  logic                 rsp_err_q;

  logic [LEN_W-1:0]     len_d;
  logic                 pre_done_d;
  logic                 shift_last_d;
  logic                 next_is_last_d;
  logic                 cap_bit_d;

  // Effective scan length and per-cycle sequence decisions.
  always_comb begin
    len_d = cmd_len_i;
    if (cmd_len_i == '0) begin
      len_d = LEN_W'(1);
    end else if (cmd_len_i > LEN_W'(MAX_LEN)) begin
      len_d = LEN_W'(MAX_LEN);
    end
    // IR preamble is TMS 1,1,0,0; DR preamble is TMS 1,0,0.
    pre_done_d     = ir_q ? (cnt_q == LEN_W'(3)) : (cnt_q == LEN_W'(2));
    shift_last_d   = (cnt_q + LEN_W'(1)) == len_q;
    next_is_last_d = (cnt_q + LEN_W'(2)) == len_q;
    // A disabled TDO driver reads as 0.
    cap_bit_d      = tdo_pad_i & tdo_padoe_i;
  end

  // Sequencer: state, counter and every pad/response output are registered.
  always_ff @(posedge tck_pad_i) begin
    if (trst_pad_i) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      len_q       <= LEN_W'(1);
      ir_q        <= 1'b0;
      data_q      <= '0;
      cap_q       <= '0;
      err_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_INIT, S_TRST: begin
          tdi_q <= 1'b0;
          if (cnt_q == RST_LO_CYC) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tms_q   <= 1'b0;
            if (state_q == S_TRST) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b0;
            end
          end else if (cnt_q == RST_HI_LAST) begin
            cnt_q <= RST_LO_CYC;
            tms_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + LEN_W'(1);
            tms_q <= 1'b1;
          end
        end

        S_IDLE: begin
          tms_q <= 1'b0;
          tdi_q <= 1'b0;
          if (cmd_valid_i) begin
            ir_q      <= (cmd_op_i == 2'b01);
            len_q     <= len_d;
            data_q    <= cmd_data_i;
            cap_q     <= '0;
            err_q     <= 1'b0;
            rsp_err_q <= 1'b0;
            cnt_q     <= '0;
            // Every command begins with TMS=1 (Select-DR or first TLR bit).
            tms_q     <= 1'b1;
            state_q   <= cmd_op_i[1] ? S_TRST : S_PRE;
          end
        end

        S_PRE: begin
          if (pre_done_d) begin
            state_q <= S_SHIFT;
            cnt_q   <= '0;
            tms_q   <= (len_q == LEN_W'(1));
            tdi_q   <= data_q[0];
          end else begin
            cnt_q <= cnt_q + LEN_W'(1);
            // Only the second IR preamble cycle (Select-IR) is TMS high.
            tms_q <= ir_q && (cnt_q == '0);
          end
        end

        S_SHIFT: begin
          cap_q[cnt_q[IDX_W-1:0]] <= cap_bit_d;
          if (!tdo_padoe_i) begin
            err_q <= 1'b1;
          end
          if (shift_last_d) begin
            state_q <= S_POST;
            cnt_q   <= '0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + LEN_W'(1);
            data_q <= data_q >> 1;
            tdi_q  <= data_q[1];
            tms_q  <= next_is_last_d;
          end
        end

        S_POST: begin
          tdi_q <= 1'b0;
          if (cnt_q == '0) begin
            cnt_q <= LEN_W'(1);
            tms_q <= 1'b0;
          end else begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tms_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= cap_q;
            rsp_err_q   <= err_q;
          end
        end

        default: begin
          state_q <= S_INIT;
          cnt_q   <= '0;
          tms_q   <= 1'b1;
          tdi_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign tms_pad_o    = tms_q;
  assign tdi_pad_o    = tdi_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_oe_err_o = rsp_err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_jtag_shift_master.sv
// Bench for jtag_shift_master: drives commands into the master, models a
// small TAP (4-bit IR capturing 0101, IDCODE 32'h149511C3) behind the pads,
// and scores responses, TMS traces and shift-cycle TDI bits.
module tb_jtag_shift_master;

  localparam logic [31:0] IDCODE_VAL = 32'h149511C3;
  localparam logic [3:0]  IR_IDCODE  = 4'b0010;

  logic        tck_pad_i = 1'b0;
  logic        trst_pad_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [5:0]  cmd_len_i;
  logic [31:0] cmd_data_i;
  logic        tms_pad_o;
  logic        tdi_pad_o;
  logic        tdo_pad_i;
  logic        tdo_padoe_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        rsp_oe_err_o;
  logic [2:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;
  int b2b_cnt = 0;
  logic tdo_stuck = 1'b0;

  jtag_shift_master #(.MAX_LEN(32), .LEN_W(6)) dut (
    .tck_pad_i   (tck_pad_i),
    .trst_pad_i  (trst_pad_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_data_i  (cmd_data_i),
    .tms_pad_o   (tms_pad_o),
    .tdi_pad_o   (tdi_pad_o),
    .tdo_pad_i   (tdo_pad_i),
    .tdo_padoe_i (tdo_padoe_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_oe_err_o(rsp_oe_err_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 tck_pad_i = ~tck_pad_i;

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR
  } tap_t;

  tap_t        tap_st;
  logic [3:0]  tap_ir;
  logic [3:0]  tap_ir_sr;
  logic [31:0] tap_dr_sr;
  logic        tap_byp;
  logic        tap_tdo;

  function automatic tap_t tap_next(tap_t s, logic t);
    case (s)
      TLR:     return t ? TLR   : RTI;
      RTI:     return t ? SELDR : RTI;
      SELDR:   return t ? SELIR : CAPDR;
      CAPDR:   return t ? EX1DR : SHDR;
      SHDR:    return t ? EX1DR : SHDR;
      EX1DR:   return t ? UPDR  : PAUDR;
      PAUDR:   return t ? EX2DR : PAUDR;
      EX2DR:   return t ? UPDR  : SHDR;
      UPDR:    return t ? SELDR : RTI;
      SELIR:   return t ? TLR   : CAPIR;
      CAPIR:   return t ? EX1IR : SHIR;
      SHIR:    return t ? EX1IR : SHIR;
      EX1IR:   return t ? UPIR  : PAUIR;
      PAUIR:   return t ? EX2IR : PAUIR;
      EX2IR:   return t ? UPIR  : SHIR;
      default: return t ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck_pad_i) begin
    if (trst_pad_i) begin
      tap_st <= TLR;
      tap_ir <= IR_IDCODE;
    end else begin
      tap_st <= tap_next(tap_st, tms_pad_o);
      case (tap_st)
        TLR:   tap_ir <= IR_IDCODE;
        CAPDR: begin tap_dr_sr <= IDCODE_VAL; tap_byp <= 1'b0; end
        SHDR:  if (tap_ir == IR_IDCODE) tap_dr_sr <= {tdi_pad_o, tap_dr_sr[31:1]};
               else tap_byp <= tdi_pad_o;
        CAPIR: tap_ir_sr <= 4'b0101;
        SHIR:  tap_ir_sr <= {tdi_pad_o, tap_ir_sr[3:1]};
        UPIR:  tap_ir <= tap_ir_sr;
        default: ;
      endcase
    end
  end

  assign tap_tdo   = (tap_st == SHDR) ? ((tap_ir == IR_IDCODE) ? tap_dr_sr[0] : tap_byp)
                   : (tap_st == SHIR) ? tap_ir_sr[0] : 1'b0;
  assign tdo_pad_i = tdo_stuck ? 1'b1 : tap_tdo;

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    int          n_cyc;
    logic [63:0] tms;
    logic [63:0] tdi_b;
    logic [63:0] tdi_m;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Expected TMS/TDI pattern straight from the command definition.
  function automatic exp_t mk(string nm, logic [1:0] op, int len, logic [31:0] d,
                              logic [31:0] rd, logic re);
    exp_t e;
    int n;
    int p;
    n = (len == 0) ? 1 : ((len > 32) ? 32 : len);
    e.name = nm; e.data = rd; e.err = re;
    e.tms = '0; e.tdi_b = '0; e.tdi_m = '0;
    if (op[1]) begin
      e.tms   = 64'b011111;
      e.n_cyc = 6;
    end else begin
      e.tms[0] = 1'b1;
      if (op == 2'b01) begin e.tms[1] = 1'b1; p = 4; end
      else p = 3;
      for (int i = 0; i < n; i++) begin
        e.tdi_m[p+i] = 1'b1;
        e.tdi_b[p+i] = d[i];
      end
      e.tms[p+n-1] = 1'b1;
      e.tms[p+n]   = 1'b1;
      e.n_cyc      = p + n + 2;
    end
    return e;
  endfunction

  // Monitor: traces each accepted command and scores it on rsp_valid_o.
  logic        mon_act = 1'b0;
  int          mon_n = 0;
  logic [63:0] mon_tms;
  logic [63:0] mon_tdi;

  always @(negedge tck_pad_i) begin
    exp_t e;
    if (trst_pad_i) begin
      mon_act = 1'b0;
      exp_q.delete();
    end else begin
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_cycles"}, 64'(mon_n), 64'(e.n_cyc));
          chk({e.name, "_tms"}, mon_tms, e.tms);
          chk({e.name, "_tdi"}, mon_tdi & e.tdi_m, e.tdi_b);
          chk({e.name, "_data"}, 64'(rsp_data_o), 64'(e.data));
          chk({e.name, "_oe_err"}, 64'(rsp_oe_err_o), 64'(e.err));
          chk({e.name, "_ready_at_rsp"}, 64'(cmd_ready_o), 64'd1);
        end
        mon_act = 1'b0;
      end else if (mon_act && mon_n < 64) begin
        mon_tms[mon_n] = tms_pad_o;
        mon_tdi[mon_n] = tdi_pad_o;
        mon_n++;
      end
      if (cmd_valid_i && cmd_ready_o) begin
        if (rsp_valid_o) b2b_cnt++;
        mon_act = 1'b1;
        mon_n   = 0;
        mon_tms = '0;
        mon_tdi = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge tck_pad_i); #1;
    end
  endtask

  task automatic send(input string nm, input logic [1:0] op, input logic [5:0] len,
                      input logic [31:0] d, input logic [31:0] rd, input logic re);
    int t = 0;
    exp_q.push_back(mk(nm, op, int'(len), d, rd, re));
    while (!cmd_ready_o && t < 500) begin step(1); t++; end
    if (t >= 500) chk({nm, "_ready_timeout"}, 64'(cmd_ready_o), 64'd1);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_len_i   = len;
    cmd_data_i  = d;
    step(1);
    cmd_valid_i = 1'b0;
    cmd_op_i    = 2'b00;
    cmd_len_i   = '0;
    cmd_data_i  = '0;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin step(1); t++; end
    if (t >= 2000) begin
      chk({nm, "_done_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  // Called in the first cycle after trst is released: 1x5, 0, then ready.
  task automatic check_init(input string nm);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("%s_tms%0d", nm, k), 64'(tms_pad_o), (k < 5) ? 64'd1 : 64'd0);
      chk($sformatf("%s_busy%0d", nm, k), 64'(cmd_ready_o), 64'd0);
      step(1);
    end
    chk({nm, "_ready"}, 64'(cmd_ready_o), 64'd1);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_tms"}, 64'(tms_pad_o), 64'd1);
    chk({nm, "_tdi"}, 64'(tdi_pad_o), 64'd0);
    chk({nm, "_ready"}, 64'(cmd_ready_o), 64'd0);
    chk({nm, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    chk({nm, "_rsp_data"}, 64'(rsp_data_o), 64'd0);
    chk({nm, "_oe_err"}, 64'(rsp_oe_err_o), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    trst_pad_i  = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_op_i    = 2'b00;
    cmd_len_i   = '0;
    cmd_data_i  = '0;
    tdo_padoe_i = 1'b1;
    step(3);
    check_reset_vals("reset");
    trst_pad_i = 1'b0;
    check_init("init");

    // IR scan loading IDCODE, then the IDCODE DR read.
    send("ir4", 2'b01, 6'd4, 32'h2, 32'h5, 1'b0);
    send("dr32", 2'b00, 6'd32, 32'h0, IDCODE_VAL, 1'b0);
    wait_done("dr32");

    // Length boundaries.
    send("dr_len1", 2'b00, 6'd1, 32'h1, 32'h1, 1'b0);
    send("dr_len0", 2'b00, 6'd0, 32'h1, 32'h1, 1'b0);
    send("dr_len40", 2'b00, 6'd40, 32'hDEADBEEF, IDCODE_VAL, 1'b0);
    send("tap_rst", 2'b10, 6'd7, 32'hFFFFFFFF, 32'h0, 1'b0);
    wait_done("bounds");

    // TDO output-enable dropped on shift bit 2 with TDO stuck high.
    tdo_stuck = 1'b1;
    send("dr8_oe", 2'b00, 6'd8, 32'hA5, 32'hFB, 1'b1);
    step(5);
    tdo_padoe_i = 1'b0;
    step(1);
    tdo_padoe_i = 1'b1;
    wait_done("dr8_oe");
    tdo_stuck = 1'b0;
    send("dr4_after_oe", 2'b00, 6'd4, 32'hA, 32'h3, 1'b0);
    chk("oe_err_cleared_on_accept", 64'(rsp_oe_err_o), 64'd0);
    chk("rsp_data_held", 64'(rsp_data_o), 64'hFB);
    wait_done("dr4_after_oe");

    // Reset pulse during shift bit 10 of a 32-bit DR scan.
    send("dr32_abort", 2'b00, 6'd32, 32'h0, IDCODE_VAL, 1'b0);
    step(13);
    trst_pad_i = 1'b1;
    step(1);
    trst_pad_i = 1'b0;
    check_reset_vals("mid_reset");
    check_init("reinit");

    // Back-to-back IR + DR pair.
    b2b_cnt = 0;
    send("b2b_ir", 2'b01, 6'd4, 32'h2, 32'h5, 1'b0);
    send("b2b_dr", 2'b00, 6'd32, 32'h12345678, IDCODE_VAL, 1'b0);
    wait_done("b2b");
    chk("b2b_accept_in_rsp_cycle", 64'(b2b_cnt), 64'd1);
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
